// File: rtl/fda_capture_pkg.sv
// fda_capture_pkg: state encodings, parameter defaults and word width shared by the capture sequencer
package fda_capture_pkg;
  localparam int WORD_W = 16;
  localparam int STROBE_LEN_DEF = 2;
  localparam int TIMEOUT_CYCLES_DEF = 65535;
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] ARM        = 3'd1;
  localparam logic [2:0] STROBE     = 3'd2;
  localparam logic [2:0] WAIT_READY = 3'd3;
  localparam logic [2:0] READ_REQ   = 3'd4;
  localparam logic [2:0] READ_WAIT  = 3'd5;
  localparam logic [2:0] HOLD       = 3'd6;
  localparam logic [2:0] DONE       = 3'd7;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/capture_trigger_detect.sv
// capture_trigger_detect: flags a rising crossing of adc samples through a threshold level
module capture_trigger_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] level,
  input  logic [7:0] sample,
  output logic       crossed
);
  logic [7:0] prevSample;
  always_ff @(posedge clk or posedge rst)
    if (rst) prevSample <= '0;
    else prevSample <= sample;
  assign crossed = enable && prevSample < level && sample >= level;
endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: arms a capture, strobes the buffer and streams its words to the host
module capture_sequencer
  import fda_capture_pkg::*;
#(
  parameter int STROBE_LEN = STROBE_LEN_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        startCapture,
  input  logic        abortCapture,
  input  logic        triggerMode,
  input  logic [7:0]  triggerLevel,
  input  word_t       wordCount,
  input  logic [7:0]  adcSample,
  output logic        dataCaptureStrobe,
  output logic        dataRead,
  input  logic        dataReadyToRead,
  input  logic        dataValid,
  input  logic        dataEmpty,
  input  word_t       captureData,
  output word_t       hostData,
  output logic        hostValid,
  input  logic        hostReady,
  output logic        busy,
  output logic        done,
  output logic        timeoutErr,
  output logic        shortRead,
  output word_t       wordsRead
);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_LEN - 1);
  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);
  logic [2:0] state;
  logic [3:0] strobeCnt;
  logic [19:0] tmoCnt;
  word_t countLatched, wordsNext;
  logic modeLatched, crossed, tmoHit;
  logic [7:0] levelLatched;
  capture_trigger_detect uTrig (
    .clk(clk),
    .rst(rst),
    .enable(state == ARM && modeLatched),
    .level(levelLatched),
    .sample(adcSample),
    .crossed(crossed)
  );
  assign wordsNext = wordsRead + WORD_W'(1);
  assign tmoHit = tmoCnt == TMO_LAST;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      strobeCnt <= '0;
      tmoCnt <= '0;
      countLatched <= '0;
      modeLatched <= 1'b0;
      levelLatched <= '0;
      hostData <= '0;
      hostValid <= 1'b0;
      timeoutErr <= 1'b0;
      shortRead <= 1'b0;
      wordsRead <= '0;
    end else if (abortCapture) begin
      state <= IDLE;
      hostValid <= 1'b0;
      hostData <= '0;
    end else begin
      case (state)
        IDLE: if (startCapture) begin
          countLatched <= wordCount == '0 ? WORD_W'(1) : wordCount;
          modeLatched <= triggerMode;
          levelLatched <= triggerLevel;
          timeoutErr <= 1'b0;
          shortRead <= 1'b0;
          wordsRead <= '0;
          tmoCnt <= '0;
          state <= ARM;
        end
        ARM: if (!modeLatched || crossed) begin
          strobeCnt <= '0;
          state <= STROBE;
        end else if (tmoHit) begin
          timeoutErr <= 1'b1;
          state <= DONE;
        end else tmoCnt <= tmoCnt + 20'd1;
        STROBE: if (strobeCnt == STROBE_LAST) begin
          tmoCnt <= '0;
          state <= WAIT_READY;
        end else strobeCnt <= strobeCnt + 4'd1;
        WAIT_READY: if (dataReadyToRead) state <= READ_REQ;
        else if (tmoHit) begin
          timeoutErr <= 1'b1;
          state <= DONE;
        end else tmoCnt <= tmoCnt + 20'd1;
        READ_REQ: begin
          tmoCnt <= '0;
          state <= READ_WAIT;
        end
        READ_WAIT: if (dataValid) begin
          hostData <= captureData;
          hostValid <= 1'b1;
          state <= HOLD;
        end else if (dataEmpty) begin
          shortRead <= 1'b1;
          state <= DONE;
        end else if (tmoHit) begin
          timeoutErr <= 1'b1;
          state <= DONE;
        end else tmoCnt <= tmoCnt + 20'd1;
        // the buffer is only re-read once the host has taken the held word
        HOLD: if (hostReady) begin
          hostValid <= 1'b0;
          wordsRead <= wordsNext;
          shortRead <= shortRead | (wordsNext != countLatched && dataEmpty);
          state <= (wordsNext == countLatched || dataEmpty) ? DONE : READ_REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign busy = state != IDLE;
  assign dataCaptureStrobe = state == STROBE && !abortCapture;
  assign dataRead = state == READ_REQ && !abortCapture;
  assign done = state == DONE && !abortCapture;
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: directed self-checking bench for capture_sequencer
module tb_capture_sequencer;
  logic clk = 1'b0, rst = 1'b1, startCapture = 1'b0, abortCapture = 1'b0, triggerMode = 1'b0;
  logic [7:0] triggerLevel = '0, adcSample = '0;
  logic [15:0] wordCount = '0, captureData = '0;
  logic dataReadyToRead = 1'b1, dataValid = 1'b0, dataEmpty = 1'b0, hostReady = 1'b1;
  logic dataCaptureStrobe, dataRead, busy, done, timeoutErr, shortRead, hostValid;
  logic [15:0] hostData, wordsRead;
  int checks = 0, failures = 0, extraReads = 0, n = 0, firstV = 0;
  logic stable;
  always #5 clk = ~clk;
  capture_sequencer #(.STROBE_LEN(2), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .startCapture(startCapture), .abortCapture(abortCapture),
    .triggerMode(triggerMode), .triggerLevel(triggerLevel), .wordCount(wordCount),
    .adcSample(adcSample), .dataCaptureStrobe(dataCaptureStrobe), .dataRead(dataRead),
    .dataReadyToRead(dataReadyToRead), .dataValid(dataValid), .dataEmpty(dataEmpty),
    .captureData(captureData), .hostData(hostData), .hostValid(hostValid),
    .hostReady(hostReady), .busy(busy), .done(done), .timeoutErr(timeoutErr),
    .shortRead(shortRead), .wordsRead(wordsRead)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask
  task automatic start(input logic mode, input logic [7:0] lvl, input logic [15:0] wc);
    triggerMode = mode;
    triggerLevel = lvl;
    wordCount = wc;
    startCapture = 1'b1;
    tick;
    startCapture = 1'b0;
  endtask
  task automatic serveWord(input logic [15:0] d, input logic emptyAfter);
    int k = 0;
    while (!dataRead && k < 300) begin
      tick;
      k++;
    end
    chk("dataRead seen", dataRead, 1);
    tick;
    dataValid = 1'b1;
    captureData = d;
    tick;
    dataValid = 1'b0;
    dataEmpty = emptyAfter;
    chk("hostValid", hostValid, 1);
    chk("hostData", hostData, d);
  endtask
  task automatic waitDone;
    int k = 0;
    extraReads = 0;
    while (!done && k < 300) begin
      if (dataRead) extraReads++;
      tick;
      k++;
    end
    chk("done pulse", done, 1);
    chk("no extra dataRead", extraReads, 0);
  endtask
  task automatic measureStrobe(output int len);
    int k = 0;
    len = 0;
    while (!dataCaptureStrobe && k < 300) begin
      tick;
      k++;
    end
    while (dataCaptureStrobe && len < 20) begin
      tick;
      len++;
    end
  endtask
  initial begin
    tick;
    tick;
    chk("rst busy", busy, 0);
    chk("rst strobe", dataCaptureStrobe, 0);
    chk("rst dataRead", dataRead, 0);
    chk("rst hostValid", hostValid, 0);
    chk("rst hostData", hostData, 0);
    chk("rst wordsRead", wordsRead, 0);
    chk("rst flags", {done, timeoutErr, shortRead}, 0);
    rst = 1'b0;
    tick;
    // mode 0, four words, host always ready
    start(1'b0, 8'h00, 16'd4);
    chk("busy after start", busy, 1);
    measureStrobe(n);
    chk("strobe length", n, 2);
    for (int i = 0; i < 4; i++) serveWord(16'(16'h0100 + i), 1'b0);
    waitDone;
    chk("m0 wordsRead", wordsRead, 4);
    chk("m0 hostValid at done", hostValid, 0);
    chk("m0 shortRead", shortRead, 0);
    tick;
    chk("done one cycle", done, 0);
    chk("idle after done", busy, 0);
    // mode 1 threshold: falling crossing ignored, rising crossing at 0x80 triggers; wordCount 0 acts as 1
    adcSample = 8'h90;
    tick;
    start(1'b1, 8'h80, 16'd0);
    adcSample = 8'h88;
    tick;
    stable = !dataCaptureStrobe;
    adcSample = 8'h70;
    tick;
    stable = stable && !dataCaptureStrobe;
    tick;
    stable = stable && !dataCaptureStrobe && busy;
    chk("falling crossing ignored", stable, 1);
    firstV = -1;
    for (int v = 'h70; v <= 'h90 && firstV < 0; v++) begin
      adcSample = 8'(v);
      tick;
      if (dataCaptureStrobe) firstV = v;
    end
    chk("trigger sample", firstV, 'h80);
    serveWord(16'h00AA, 1'b0);
    waitDone;
    chk("wc0 wordsRead", wordsRead, 1);
    tick;
    // buffer empties after five of eight words
    start(1'b0, 8'h00, 16'd8);
    for (int i = 0; i < 5; i++) serveWord(16'(16'h0200 + i), i == 4);
    waitDone;
    chk("short shortRead", shortRead, 1);
    chk("short wordsRead", wordsRead, 5);
    chk("short timeoutErr", timeoutErr, 0);
    dataEmpty = 1'b0;
    tick;
    // host stalls in HOLD well past the timeout limit; a start while busy is ignored
    hostReady = 1'b0;
    start(1'b0, 8'h00, 16'd2);
    serveWord(16'hA5A5, 1'b0);
    stable = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (i == 5) begin
        wordCount = 16'd1;
        startCapture = 1'b1;
      end
      tick;
      startCapture = 1'b0;
      stable = stable && hostValid && hostData == 16'hA5A5 && !dataRead && !timeoutErr && busy;
    end
    chk("HOLD stable", stable, 1);
    hostReady = 1'b1;
    serveWord(16'h5A5A, 1'b0);
    waitDone;
    chk("stall wordsRead", wordsRead, 2);
    chk("stall timeoutErr", timeoutErr, 0);
    tick;
    // dataReadyToRead never rises
    dataReadyToRead = 1'b0;
    start(1'b0, 8'h00, 16'd1);
    measureStrobe(n);
    n = 0;
    while (!done && n < 300) begin
      tick;
      n++;
    end
    chk("timeout cycles", n, 100);
    chk("timeoutErr", timeoutErr, 1);
    tick;
    chk("timeoutErr sticky", timeoutErr, 1);
    chk("idle after timeout", busy, 0);
    dataReadyToRead = 1'b1;
    // abort in READ_WAIT
    start(1'b0, 8'h00, 16'd3);
    n = 0;
    while (!dataRead && n < 300) begin
      tick;
      n++;
    end
    tick;
    abortCapture = 1'b1;
    tick;
    abortCapture = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort hostValid", hostValid, 0);
    chk("abort hostData", hostData, 0);
    chk("abort wordsRead", wordsRead, 0);
    chk("abort outputs", {done, dataRead, dataCaptureStrobe, timeoutErr, shortRead}, 0);
    tick;
    chk("abort no done", done, 0);
    startCapture = 1'b1;
    abortCapture = 1'b1;
    tick;
    startCapture = 1'b0;
    abortCapture = 1'b0;
    chk("abort beats start", busy, 0);
    start(1'b0, 8'h00, 16'd1);
    serveWord(16'h1234, 1'b0);
    waitDone;
    chk("after abort wordsRead", wordsRead, 1);
    tick;
    // reset while holding a word
    hostReady = 1'b0;
    start(1'b0, 8'h00, 16'd2);
    serveWord(16'hBEEF, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst hold hostValid", hostValid, 0);
    chk("rst hold hostData", hostData, 0);
    chk("rst hold busy", busy, 0);
    chk("rst hold wordsRead", wordsRead, 0);
    tick;
    rst = 1'b0;
    hostReady = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      stable = stable && !done && !dataCaptureStrobe && !dataRead && !busy;
    end
    chk("quiet after reset", stable, 1);
    start(1'b0, 8'h00, 16'd1);
    serveWord(16'hC0DE, 1'b0);
    waitDone;
    chk("after reset wordsRead", wordsRead, 1);
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- STROBE_LEN, 2: dataCaptureStrobe high time in clk cycles (1..15).
- TIMEOUT_CYCLES, 65535: wait-state limit in clk cycles (1..2^20-1).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- startCapture  in  1  one-cycle request to begin a capture.
- abortCapture  in  1  cancel any capture in progress.
- triggerMode  in  1  0 = immediate, 1 = threshold on adcSample.
- triggerLevel  in  8  threshold level.
- wordCount  in  16  words to read out; 0 is treated as 1.
- adcSample  in  8  live ADC sample used for the threshold trigger.
- dataCaptureStrobe  out  1  start pulse to the capture buffer.
- dataRead  out  1  one-cycle read request to the capture buffer.
- dataReadyToRead  in  1  buffer holds data.
- dataValid  in  1  captureData valid this cycle.
- dataEmpty  in  1  buffer drained.
- captureData  in  16  buffer read word.
- hostData  out  16  word presented to the host.
- hostValid  out  1  hostData valid; held until hostReady.
- hostReady  in  1  host accepts hostData.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- timeoutErr  out  1  sticky timeout flag.
- shortRead  out  1  sticky flag: buffer emptied before wordCount was reached.
- wordsRead  out  16  count of host handshakes in the current capture.

Function
REQ-003 The FSM SHALL have the states IDLE, ARM, STROBE, WAIT_READY, READ_REQ, READ_WAIT, HOLD and DONE.
REQ-004 IDLE: on startCapture, latch wordCount, triggerMode and triggerLevel; clear timeoutErr, shortRead and wordsRead; go to ARM next cycle.
REQ-005 ARM, mode 0: go to STROBE next cycle. ARM, mode 1: go to STROBE on the first cycle where the registered previous sample is below triggerLevel and adcSample is greater than or equal to it (rising crossing only).
REQ-006 STROBE: hold dataCaptureStrobe high for exactly STROBE_LEN cycles, then go to WAIT_READY.
REQ-007 WAIT_READY: when dataReadyToRead is high, go to READ_REQ.
REQ-008 READ_REQ: assert dataRead for one cycle, then go to READ_WAIT.
REQ-009 READ_WAIT, on dataValid: register captureData into hostData, set hostValid, go to HOLD. If dataEmpty is high and dataValid is low: set shortRead, go to DONE. dataValid has priority over dataEmpty.
REQ-010 HOLD: hostData and hostValid stay stable until hostReady. On the handshake, increment wordsRead. Then:
- wordsRead reaches the latched count: go to DONE.
- else dataEmpty high: set shortRead, go to DONE.
- else: go to READ_REQ.
REQ-011 DONE: pulse done for one cycle, deassert hostValid, go to IDLE.
REQ-012 Timeout counter: cleared on entry to ARM (mode 1), WAIT_READY and READ_WAIT. When it reaches TIMEOUT_CYCLES, set timeoutErr and go to DONE. HOLD never times out.
REQ-013 abortCapture in any non-IDLE state: go to IDLE next cycle; force strobe, dataRead and hostValid low; no done pulse. abortCapture SHALL take priority over startCapture in the same cycle.
REQ-014 startCapture while busy SHALL be ignored.
REQ-015 dataRead SHALL never be asserted while hostValid is high; there is at most one outstanding read.

Reset
REQ-016 rst SHALL asynchronously force state IDLE and drive every output to 0, including hostData, wordsRead and both sticky flags; internal counters SHALL also clear.
REQ-017 Reset asserted mid-capture SHALL behave as REQ-016, with no done pulse and no glitch on dataCaptureStrobe or dataRead after release.

Structure
REQ-018 Package fda_capture_pkg SHALL hold the state encodings, the TIMEOUT_CYCLES and STROBE_LEN defaults, and the word width of 16.
REQ-019 The threshold-crossing logic SHALL be the sub-module capture_trigger_detect (registered previous sample plus compare, with an enable input).

Verification
REQ-020 The bench SHALL cover:
- Mode 0, wordCount=4, hostReady tied high, buffer returns 0x0100..0x0103 -> one strobe of 2 cycles, 4 dataRead pulses, hostData sequence matches, done=1, wordsRead=4.
- Mode 1, level=0x80, adcSample ramps 0x70..0x90 -> strobe begins within 2 cycles of the sample equal to 0x80; a falling crossing causes no trigger.
- wordCount=8, buffer empties after 5 words -> shortRead=1, wordsRead=5, done pulse.
- hostReady low for 20 cycles during HOLD -> hostData stable, no extra dataRead, no timeout.
- dataReadyToRead never rises, TIMEOUT_CYCLES=100 -> timeoutErr=1 and done pulse after 100 cycles in WAIT_READY.
- abortCapture in READ_WAIT, and rst in HOLD -> IDLE, all outputs 0, no done pulse; a new startCapture then works normally.
